// File: rtl/mc_pkg.sv
// ============================================================================
// Module   : mc_pkg
// Purpose  : Opcode, state and datapath-select encodings for the multicycle
//            MIPS main controller.
// Revision : 1.0
// ============================================================================
`default_nettype none

package mc_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [3:0] S_FETCH   = 4'd0;
    localparam logic [3:0] S_DECODE  = 4'd1;
    localparam logic [3:0] S_MEMADR  = 4'd2;
    localparam logic [3:0] S_MEMRD   = 4'd3;
    localparam logic [3:0] S_MEMWB   = 4'd4;
    localparam logic [3:0] S_MEMWR   = 4'd5;
    localparam logic [3:0] S_EXEC    = 4'd6;
    localparam logic [3:0] S_RWB     = 4'd7;
    localparam logic [3:0] S_BRANCH  = 4'd8;
    localparam logic [3:0] S_JUMP    = 4'd9;
    localparam logic [3:0] S_ADDI_EX = 4'd10;
    localparam logic [3:0] S_ADDI_WB = 4'd11;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG      = 2'b00;
    localparam logic [1:0] SRCB_FOUR     = 2'b01;
    localparam logic [1:0] SRCB_SEXT     = 2'b10;
    localparam logic [1:0] SRCB_SEXT_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

`default_nettype wire

// File: rtl/mc_opdecode.sv
// ============================================================================
// Module   : mc_opdecode
// Purpose  : Maps an opcode to the state that follows DECODE, plus legality.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mc_opdecode
    import mc_pkg::*;
(
    input  logic [5:0] i_opcode,
    output logic [3:0] o_next_state,
    output logic       o_legal
);

    always_comb begin
        o_next_state = S_FETCH;
        o_legal      = 1'b1;
        case (i_opcode)
            OP_LW, OP_SW:    o_next_state = S_MEMADR;
            OP_RTYPE:        o_next_state = S_EXEC;
            OP_BEQ, OP_BNE:  o_next_state = S_BRANCH;
            OP_J:            o_next_state = S_JUMP;
            OP_ADDI:         o_next_state = S_ADDI_EX;
            default:         o_legal      = 1'b0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mc_control.sv
// ============================================================================
// Module   : mc_control
// Purpose  : Multicycle MIPS main controller: FSM, datapath control decode,
//            retired-instruction counter and sticky illegal-opcode flag.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mc_control
    import mc_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  OpCode,
    input  logic        mem_ready,
    output logic        PCWrite,
    output logic        PCWriteCond,
    output logic        IorD,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        MemtoReg,
    output logic        IRWrite,
    output logic        RegWrite,
    output logic        RegDst,
    output logic        ALUSrcA,
    output logic        Branch,
    output logic        NotBranch,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ALUOp,
    output logic [1:0]  PCSource,
    output logic [3:0]  state,
    output logic        illegal_op,
    output logic [31:0] instret
);

    logic [3:0]  r_state;
    logic [3:0]  w_next_state;
    logic [5:0]  r_op_q;
    logic        r_illegal;
    logic [31:0] r_instret;
    logic [3:0]  w_dec_next;
    logic        w_dec_legal;
    logic        w_retire;

    // Decode always looks at the live opcode; it is only consulted in DECODE.
    mc_opdecode u_opdecode (
        .i_opcode     (OpCode),
        .o_next_state (w_dec_next),
        .o_legal      (w_dec_legal)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = S_FETCH;
        case (r_state)
            S_FETCH:   w_next_state = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE:  w_next_state = w_dec_next;
            S_MEMADR:  w_next_state = (r_op_q == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:   w_next_state = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:   w_next_state = mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:    w_next_state = S_RWB;
            S_ADDI_EX: w_next_state = S_ADDI_WB;
            default:   w_next_state = S_FETCH;
        endcase
    end

    // Everything is gated by reset so an aborted instruction writes nothing.
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        MemtoReg    = 1'b0;
        IRWrite     = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = 1'b0;
        ALUSrcA     = 1'b0;
        Branch      = 1'b0;
        NotBranch   = 1'b0;
        ALUSrcB     = SRCB_REG;
        ALUOp       = ALUOP_ADD;
        PCSource    = PCSRC_ALU;
        if (reset) begin
            case (r_state)
                S_FETCH: begin
                    MemRead = 1'b1;
                    ALUSrcB = SRCB_FOUR;
                    IRWrite = mem_ready;
                    PCWrite = mem_ready;
                end
                S_DECODE:  ALUSrcB = SRCB_SEXT_SH2;
                S_MEMADR: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = SRCB_SEXT;
                end
                S_MEMRD: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                end
                S_MEMWB: begin
                    RegWrite = 1'b1;
                    MemtoReg = 1'b1;
                end
                S_MEMWR: begin
                    MemWrite = 1'b1;
                    IorD     = 1'b1;
                end
                S_EXEC: begin
                    ALUSrcA = 1'b1;
                    ALUOp   = ALUOP_FUNCT;
                end
                S_RWB: begin
                    RegWrite = 1'b1;
                    RegDst   = 1'b1;
                end
                S_BRANCH: begin
                    ALUSrcA     = 1'b1;
                    ALUOp       = ALUOP_SUB;
                    PCWriteCond = 1'b1;
                    PCSource    = PCSRC_ALUOUT;
                    Branch      = (r_op_q == OP_BEQ);
                    NotBranch   = (r_op_q == OP_BNE);
                end
                S_JUMP: begin
                    PCWrite  = 1'b1;
                    PCSource = PCSRC_JUMP;
                end
                S_ADDI_EX: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = SRCB_SEXT;
                end
                S_ADDI_WB: RegWrite = 1'b1;
                default: ;
            endcase
        end
    end

    assign w_retire = (r_state == S_MEMWB)
                   || ((r_state == S_MEMWR) && mem_ready)
                   || (r_state == S_RWB)
                   || (r_state == S_BRANCH)
                   || (r_state == S_JUMP)
                   || (r_state == S_ADDI_WB);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_op_q    <= 6'd0;
            r_illegal <= 1'b0;
            r_instret <= 32'd0;
        end else begin
            if (r_state == S_DECODE) begin
                r_op_q <= OpCode;
                if (!w_dec_legal) begin
                    r_illegal <= 1'b1;
                end
            end
            if (w_retire) begin
                r_instret <= r_instret + 32'd1;
            end
        end
    end

    assign state      = r_state;
    assign illegal_op = r_illegal;
    assign instret    = r_instret;

endmodule

`default_nettype wire

// File: tb/tb_mc_control.sv
// ============================================================================
// Module   : tb_mc_control
// Purpose  : Self-checking bench for mc_control against an instruction-level
//            reference model (per-opcode state paths and per-state outputs).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mc_control;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [5:0]  OpCode = 6'd0;
    logic        mem_ready = 1'b0;
    logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg;
    logic        IRWrite, RegWrite, RegDst, ALUSrcA, Branch, NotBranch;
    logic [1:0]  ALUSrcB, ALUOp, PCSource;
    logic [3:0]  state;
    logic        illegal_op;
    logic [31:0] instret;
    logic [17:0] w_ctrl;

    int          n_vec = 0;
    int          n_fail = 0;
    int          cyc = 0;
    logic [31:0] m_cnt = 32'd0;
    logic        m_ill = 1'b0;
    bit          g_rand = 1'b0;
    bit          rdy_q[$];

    typedef int path_t[$];

    mc_control dut (
        .clk         (clk),
        .reset       (reset),
        .OpCode      (OpCode),
        .mem_ready   (mem_ready),
        .PCWrite     (PCWrite),
        .PCWriteCond (PCWriteCond),
        .IorD        (IorD),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .MemtoReg    (MemtoReg),
        .IRWrite     (IRWrite),
        .RegWrite    (RegWrite),
        .RegDst      (RegDst),
        .ALUSrcA     (ALUSrcA),
        .Branch      (Branch),
        .NotBranch   (NotBranch),
        .ALUSrcB     (ALUSrcB),
        .ALUOp       (ALUOp),
        .PCSource    (PCSource),
        .state       (state),
        .illegal_op  (illegal_op),
        .instret     (instret)
    );

    assign w_ctrl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg,
                     IRWrite, RegWrite, RegDst, ALUSrcA, Branch, NotBranch,
                     ALUSrcB, ALUOp, PCSource};

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic bit is_legal(input logic [5:0] op);
        return op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100,
                          6'b000101, 6'b000010, 6'b001000};
    endfunction

    // Sequence of states an instruction visits, ignoring stall repeats.
    function automatic path_t path_for(input logic [5:0] op);
        path_t p;
        case (op)
            6'b100011: p = '{0, 1, 2, 3, 4};
            6'b101011: p = '{0, 1, 2, 5};
            6'b000000: p = '{0, 1, 6, 7};
            6'b001000: p = '{0, 1, 10, 11};
            6'b000100: p = '{0, 1, 8};
            6'b000101: p = '{0, 1, 8};
            6'b000010: p = '{0, 1, 9};
            default:   p = '{0, 1};
        endcase
        return p;
    endfunction

    function automatic logic [17:0] exp_ctrl(input int s, input logic [5:0] op, input logic mr);
        logic pcw, pcwc, iord, mrd, mwr, m2r, irw, rw, rdst, asa, br, nbr;
        logic [1:0] srcb, aop, pcs;
        {pcw, pcwc, iord, mrd, mwr, m2r, irw, rw, rdst, asa, br, nbr} = '0;
        srcb = 2'b00; aop = 2'b00; pcs = 2'b00;
        case (s)
            0:  begin mrd = 1; srcb = 2'b01; irw = mr; pcw = mr; end
            1:  srcb = 2'b11;
            2:  begin asa = 1; srcb = 2'b10; end
            3:  begin mrd = 1; iord = 1; end
            4:  begin rw = 1; m2r = 1; end
            5:  begin mwr = 1; iord = 1; end
            6:  begin asa = 1; aop = 2'b10; end
            7:  begin rw = 1; rdst = 1; end
            8:  begin asa = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01;
                      br = (op == 6'b000100); nbr = (op == 6'b000101); end
            9:  begin pcw = 1; pcs = 2'b10; end
            10: begin asa = 1; srcb = 2'b10; end
            11: rw = 1;
            default: ;
        endcase
        return {pcw, pcwc, iord, mrd, mwr, m2r, irw, rw, rdst, asa, br, nbr, srcb, aop, pcs};
    endfunction

    function automatic bit next_ready();
        if (rdy_q.size() > 0) return rdy_q.pop_front();
        if (g_rand) return ($urandom_range(0, 3) != 0);
        return 1'b1;
    endfunction

    // Runs one instruction; abort_idx >= 0 asserts reset in that path step.
    task automatic run_instr(input logic [5:0] op, input int abort_idx);
        path_t p;
        bit    mr;
        bit    done;
        logic [17:0] exp;
        p = path_for(op);
        for (int i = 0; i < p.size(); i++) begin
            done = 1'b0;
            while (!done) begin
                #2;
                mr        = next_ready();
                mem_ready = mr;
                OpCode    = (p[i] == 1) ? op : 6'($urandom);
                reset     = (i == abort_idx) ? 1'b0 : 1'b1;
                #1;
                exp = (i == abort_idx) ? 18'd0 : exp_ctrl(p[i], op, mr);
                n_vec++;
                if (state !== 4'(p[i])) begin
                    $display("FAIL state op=%b step=%0d: got %0d want %0d", op, i, state, p[i]);
                    n_fail++;
                end
                n_vec++;
                if (w_ctrl !== exp) begin
                    $display("FAIL ctrl op=%b state=%0d mr=%b: got %b want %b", op, p[i], mr, w_ctrl, exp);
                    n_fail++;
                end
                n_vec++;
                if (instret !== m_cnt) begin
                    $display("FAIL instret op=%b state=%0d: got %0d want %0d", op, p[i], instret, m_cnt);
                    n_fail++;
                end
                n_vec++;
                if (illegal_op !== m_ill) begin
                    $display("FAIL illegal_op op=%b state=%0d: got %b want %b", op, p[i], illegal_op, m_ill);
                    n_fail++;
                end
                @(posedge clk);
                cyc++;
                if (i == abort_idx) begin
                    m_cnt = 32'd0;
                    m_ill = 1'b0;
                    return;
                end
                done = !(p[i] == 0 || p[i] == 3 || p[i] == 5) || mr;
                if (done && i == p.size() - 1 && is_legal(op)) m_cnt = m_cnt + 32'd1;
                if (p[i] == 1 && !is_legal(op)) m_ill = 1'b1;
            end
        end
    endtask

    task automatic do_reset();
        for (int k = 0; k < 3; k++) begin
            #2;
            reset     = 1'b0;
            mem_ready = 1'b1;
            OpCode    = 6'($urandom);
            #1;
            n_vec++;
            if (w_ctrl !== 18'd0) begin
                $display("FAIL reset_ctrl cycle %0d: got %b want 0", k, w_ctrl);
                n_fail++;
            end
            @(posedge clk);
            cyc++;
        end
        m_cnt = 32'd0;
        m_ill = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_vec++;
        if (state !== 4'd0 || instret !== 32'd0 || illegal_op !== 1'b0) begin
            $display("FAIL reset_regs: got state=%0d instret=%0d ill=%b want 0/0/0", state, instret, illegal_op);
            n_fail++;
        end
        reset     = 1'b1;
        mem_ready = 1'b1;
        #1;
        n_vec++;
        if ({MemRead, IRWrite, PCWrite} !== 3'b111 || w_ctrl !== exp_ctrl(0, 6'd0, 1'b1)) begin
            $display("FAIL release_fetch: got %b want %b", w_ctrl, exp_ctrl(0, 6'd0, 1'b1));
            n_fail++;
        end
        mem_ready = 1'b0;
        @(posedge clk);
        cyc++;
    endtask

    task automatic test_lw_sw();
        int c0;
        do_reset();
        c0 = cyc;
        run_instr(6'b100011, -1);
        run_instr(6'b101011, -1);
        #1;
        n_vec++;
        if (cyc - c0 !== 9 || instret !== 32'd2) begin
            $display("FAIL lw_sw_total: got cycles=%0d instret=%0d want 9/2", cyc - c0, instret);
            n_fail++;
        end
    endtask

    task automatic test_branches();
        int c0;
        do_reset();
        c0 = cyc;
        run_instr(6'b000100, -1);
        run_instr(6'b000101, -1);
        run_instr(6'b000010, -1);
        #1;
        n_vec++;
        if (cyc - c0 !== 9 || instret !== 32'd3) begin
            $display("FAIL branch_total: got cycles=%0d instret=%0d want 9/3", cyc - c0, instret);
            n_fail++;
        end
    endtask

    task automatic test_stall();
        int c0;
        do_reset();
        rdy_q = '{0, 0, 1, 1, 1, 0, 0, 0, 1, 1};
        c0 = cyc;
        run_instr(6'b100011, -1);
        #1;
        n_vec++;
        if (cyc - c0 !== 10 || instret !== 32'd1) begin
            $display("FAIL stall_total: got cycles=%0d instret=%0d want 10/1", cyc - c0, instret);
            n_fail++;
        end
        rdy_q.delete();
    endtask

    task automatic test_illegal();
        int c0;
        do_reset();
        c0 = cyc;
        run_instr(6'b111111, -1);
        #1;
        n_vec++;
        if (cyc - c0 !== 2 || illegal_op !== 1'b1) begin
            $display("FAIL illegal_seq: got cycles=%0d ill=%b want 2/1", cyc - c0, illegal_op);
            n_fail++;
        end
        run_instr(6'b001000, -1);
        #1;
        n_vec++;
        if (illegal_op !== 1'b1 || instret !== 32'd1) begin
            $display("FAIL illegal_sticky: got ill=%b instret=%0d want 1/1", illegal_op, instret);
            n_fail++;
        end
    endtask

    task automatic test_wrap_and_abort();
        do_reset();
        #1;
        force dut.r_instret = 32'hFFFF_FFFF;
        #1;
        release dut.r_instret;
        m_cnt = 32'hFFFF_FFFF;
        run_instr(6'b000000, -1);
        #1;
        n_vec++;
        if (instret !== 32'd0) begin
            $display("FAIL instret_wrap: got %h want 00000000", instret);
            n_fail++;
        end
        run_instr(6'b000000, 2);
        run_instr(6'b001000, -1);
        run_instr(6'b000000, 3);
        run_instr(6'b101011, 3);
        run_instr(6'b000010, -1);
    endtask

    task automatic test_random();
        logic [5:0] ops [7] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
                                6'b000101, 6'b000010, 6'b001000};
        logic [5:0] op;
        int         ab;
        do_reset();
        g_rand = 1'b1;
        for (int n = 0; n < 80; n++) begin
            op = ($urandom_range(0, 4) == 0) ? 6'($urandom) : ops[$urandom_range(0, 6)];
            ab = ($urandom_range(0, 14) == 0) ? int'($urandom_range(0, path_for(op).size() - 1)) : -1;
            run_instr(op, ab);
        end
        g_rand = 1'b0;
        #1;
        n_vec++;
        if (instret !== m_cnt || illegal_op !== m_ill) begin
            $display("FAIL random_end: got instret=%0d ill=%b want %0d/%b", instret, illegal_op, m_cnt, m_ill);
            n_fail++;
        end
    endtask

    initial begin
        test_reset();
        test_lw_sw();
        test_branches();
        test_stall();
        test_illegal();
        test_wrap_and_abort();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
